// File: rtl/mcdf_slave_channel_v2.sv
// mcdf_slave_channel_v2
// Channel slave for the MCDF. Upstream words are buffered in an inline
// synchronous FIFO. Once a full packet is buffered the slave requests the
// arbiter. On grant it emits one packet of registered beats, marking the
// final beat with slvx_last_o. Dropping slvx_en_i flushes the channel at
// the next clock edge.
module mcdf_slave_channel_v2 #(
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH        = 64,
    parameter int ADDR_W       = $clog2(DEPTH),
    parameter int READY_MARGIN = DEPTH / 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  chx_valid_i,
    input  logic [DATA_WIDTH-1:0] chx_data_i,
    output logic                  chx_ready_o,
    input  logic                  slvx_en_i,
    input  logic [2:0]            slvx_pkglen_i,
    input  logic                  a2sx_ack_i,
    output logic                  slvx_req_o,
    output logic [DATA_WIDTH-1:0] slvx_data_o,
    output logic                  slvx_val_o,
    output logic                  slvx_last_o,
    output logic [ADDR_W:0]       margin_o,
    output logic                  busy_o
);

    localparam int CNT_W = ADDR_W + 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    localparam logic [10:0]       DEPTH_L  = 11'(DEPTH);
    localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  MARGIN_C = CNT_W'(READY_MARGIN);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [10:0]       BEAT_ONE = 11'd1;

    // Packet length saturated to the FIFO depth; a packet longer than the
    // buffer could never be fully buffered and would deadlock the request.
    function automatic logic [10:0] clamp_len(input logic [2:0] code);
        logic [10:0] full_len;
        full_len  = 11'd4 << code;
        clamp_len = (full_len > DEPTH_L) ? DEPTH_L : full_len;
    endfunction

    // FIFO storage and bookkeeping
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_W-1:0]     wr_ptr;
    logic [ADDR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]      count;

    // Burst control
    logic [0:0]            state;
    logic [10:0]           burst_len;
    logic [10:0]           beat_cnt;
    logic [10:0]           pkglen_eff;

    // Handshake / pop stage (p0) and registered beat stage (p1)
    logic                  wr_en;
    logic                  rd_en_p0;
    logic                  last_p0;
    logic                  vld_p1;
    logic                  last_p1;
    logic [DATA_WIDTH-1:0] data_p1;

    assign pkglen_eff = clamp_len(slvx_pkglen_i);
    assign margin_o   = DEPTH_C - count;

    // Ready needs a free-entry margin so upstream sees headroom; it is held
    // low during reset so no word is accepted while state is clearing.
    assign chx_ready_o = ~rst_i & slvx_en_i & (margin_o >= MARGIN_C);
    assign wr_en       = chx_valid_i & chx_ready_o;

    // Request only from IDLE, so a grant arriving mid-burst is ignored.
    assign slvx_req_o = ~rst_i & (state == IDLE) & slvx_en_i
                        & (11'(count) >= pkglen_eff);

    // A pop happens on every SEND cycle; disabling the channel cancels it
    // because the flush wins at the same edge.
    assign rd_en_p0 = (state == SEND) & slvx_en_i;
    assign last_p0  = rd_en_p0 & (beat_cnt == (burst_len - BEAT_ONE));

    assign busy_o      = (state == SEND);
    assign slvx_val_o  = vld_p1;
    assign slvx_last_o = last_p1;
    assign slvx_data_o = data_p1;

    // Storage write; contents need no reset because count gates every read.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_ptr] <= chx_data_i;
        end
    end

    // Pointers wrap modulo DEPTH; count is kept separately so full and
    // empty are distinguishable without an extra pointer bit.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (!slvx_en_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_en_p0) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({wr_en, rd_en_p0})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Burst FSM: latch the packet length on grant so later length changes
    // cannot shorten or stretch the packet in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            burst_len <= '0;
            beat_cnt  <= '0;
        end else if (!slvx_en_i) begin
            state    <= IDLE;
            beat_cnt <= '0;
        end else if (state == IDLE) begin
            if (slvx_req_o && a2sx_ack_i) begin
                state     <= SEND;
                burst_len <= pkglen_eff;
                beat_cnt  <= '0;
            end
        end else begin
            beat_cnt <= beat_cnt + BEAT_ONE;
            if (last_p0) begin
                state <= IDLE;
            end
        end
    end

    // Stage p0 -> p1: register the popped word with its valid and last flags.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
            data_p1 <= '0;
        end else begin
            vld_p1  <= rd_en_p0;
            last_p1 <= last_p0;
            if (rd_en_p0) begin
                data_p1 <= mem[rd_ptr];
            end
        end
    end

endmodule

// File: tb/tb_mcdf_slave_channel_v2.sv
// Testbench for mcdf_slave_channel_v2: two instances (ready margin 32 and 1)
// share stimulus; a queue-based packet model predicts every output.
module tb_mcdf_slave_channel_v2;

    localparam int DW  = 32;
    localparam int DEP = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          chx_valid;
    logic [DW-1:0] chx_data;
    logic [2:0]    pkglen;
    logic          ack;

    logic          ready_a, req_a, val_a, last_a, busy_a;
    logic [DW-1:0] data_a;
    logic [6:0]    margin_a;
    logic          ready_b, req_b, val_b, last_b, busy_b;
    logic [DW-1:0] data_b;
    logic [6:0]    margin_b;

    always #5 clk = ~clk;

    mcdf_slave_channel_v2 #(.DATA_WIDTH(DW), .DEPTH(DEP), .READY_MARGIN(32)) dut_a (
        .clk_i(clk), .rst_i(rst), .chx_valid_i(chx_valid), .chx_data_i(chx_data),
        .chx_ready_o(ready_a), .slvx_en_i(en), .slvx_pkglen_i(pkglen),
        .a2sx_ack_i(ack), .slvx_req_o(req_a), .slvx_data_o(data_a),
        .slvx_val_o(val_a), .slvx_last_o(last_a), .margin_o(margin_a), .busy_o(busy_a)
    );

    mcdf_slave_channel_v2 #(.DATA_WIDTH(DW), .DEPTH(DEP), .READY_MARGIN(1)) dut_b (
        .clk_i(clk), .rst_i(rst), .chx_valid_i(chx_valid), .chx_data_i(chx_data),
        .chx_ready_o(ready_b), .slvx_en_i(en), .slvx_pkglen_i(pkglen),
        .a2sx_ack_i(ack), .slvx_req_o(req_b), .slvx_data_o(data_b),
        .slvx_val_o(val_b), .slvx_last_o(last_b), .margin_o(margin_b), .busy_o(busy_b)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    bit            m_send[2];
    int            m_rem[2];
    bit            m_val[2];
    bit            m_last[2];
    logic [DW-1:0] m_data[2];
    int            rmargin[2] = '{32, 1};
    bit            log_en = 1'b0;
    logic [DW-1:0] in_log[$];
    logic [DW-1:0] out_log[$];

    function automatic int q_size(input int i);
        return (i == 0) ? q0.size() : q1.size();
    endfunction

    function automatic int eff_len(input logic [2:0] c);
        int l;
        l = 4 << c;
        return (l > DEP) ? DEP : l;
    endfunction

    function automatic bit m_ready(input int i);
        return !rst && en && ((DEP - q_size(i)) >= rmargin[i]);
    endfunction

    function automatic bit m_req(input int i);
        return !rst && en && !m_send[i] && (q_size(i) >= eff_len(pkglen));
    endfunction

    task automatic m_clear(input int i);
        if (i == 0) q0.delete(); else q1.delete();
        m_send[i] = 1'b0;
        m_rem[i]  = 0;
        m_val[i]  = 1'b0;
        m_last[i] = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_clear(i);
            m_data[i] = '0;
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            bit wr;
            bit rq;
            wr = chx_valid && m_ready(i);
            rq = m_req(i);
            if (rst) begin
                m_clear(i);
                m_data[i] = '0;
            end else if (!en) begin
                m_clear(i);
            end else begin
                if (m_send[i]) begin
                    m_data[i] = (i == 0) ? q0.pop_front() : q1.pop_front();
                    m_val[i]  = 1'b1;
                    m_rem[i]  = m_rem[i] - 1;
                    m_last[i] = (m_rem[i] == 0);
                    if (m_rem[i] == 0) m_send[i] = 1'b0;
                end else begin
                    m_val[i]  = 1'b0;
                    m_last[i] = 1'b0;
                end
                if (wr) begin
                    if (i == 0) q0.push_back(chx_data);
                    else begin
                        q1.push_back(chx_data);
                        if (log_en) in_log.push_back(chx_data);
                    end
                end
                if (rq && ack) begin
                    m_send[i] = 1'b1;
                    m_rem[i]  = eff_len(pkglen);
                end
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_all();
        logic uf;
        chk("ready_a",  ready_a,  m_ready(0));
        chk("req_a",    req_a,    m_req(0));
        chk("val_a",    val_a,    m_val[0]);
        chk("last_a",   last_a,   m_last[0]);
        chk("margin_a", margin_a, DEP - q_size(0));
        chk("busy_a",   busy_a,   m_send[0]);
        if (m_val[0]) chk("data_a", data_a, m_data[0]);
        chk("ready_b",  ready_b,  m_ready(1));
        chk("req_b",    req_b,    m_req(1));
        chk("val_b",    val_b,    m_val[1]);
        chk("last_b",   last_b,   m_last[1]);
        chk("margin_b", margin_b, DEP - q_size(1));
        chk("busy_b",   busy_b,   m_send[1]);
        if (m_val[1]) chk("data_b", data_b, m_data[1]);
        uf = (dut_a.state == 1'b1) && en && (dut_a.count == 0);
        chk("no_underflow_a", uf, 1'b0);
        uf = (dut_b.state == 1'b1) && en && (dut_b.count == 0);
        chk("no_underflow_b", uf, 1'b0);
        if (log_en && val_b) out_log.push_back(data_b);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic flush();
        en        = 1'b0;
        chx_valid = 1'b0;
        ack       = 1'b0;
        cycle();
        en = 1'b1;
    endtask

    task automatic write_words(input int n);
        chx_valid = 1'b1;
        for (int k = 0; k < n; k++) begin
            chx_data = $urandom;
            cycle();
        end
        chx_valid = 1'b0;
    endtask

    typedef struct {
        logic [2:0] code;
        int         nwords;
        bit         do_ack;
        bit         exp_req;
        bit         exp_ready;
        int         exp_margin;
    } vec_t;

    vec_t tbl[6];

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] w[10];
        int beats;
        int lastpos;
        int guard;
        int bad;

        tbl[0] = '{3'd0,  3, 1'b1, 1'b0, 1'b1, 61};
        tbl[1] = '{3'd0,  4, 1'b0, 1'b1, 1'b1, 60};
        tbl[2] = '{3'd1,  7, 1'b0, 1'b0, 1'b1, 57};
        tbl[3] = '{3'd1,  8, 1'b0, 1'b1, 1'b1, 56};
        tbl[4] = '{3'd3, 32, 1'b0, 1'b1, 1'b1, 32};
        tbl[5] = '{3'd4, 40, 1'b0, 1'b0, 1'b0, 31};

        rst = 1'b1; en = 1'b0; chx_valid = 1'b0; chx_data = '0; pkglen = 3'd0; ack = 1'b0;
        model_reset();
        cycle();
        cycle();
        chk("rst_margin", margin_a, 7'd64);
        chk("rst_ready",  ready_a,  1'b0);
        chk("rst_val",    val_a,    1'b0);
        chk("rst_data",   data_a,   32'd0);
        chk("rst_busy",   busy_a,   1'b0);
        rst = 1'b0;
        en  = 1'b1;
        cycle();

        // Table: fill levels, request thresholds, ready margin, ignored ack
        for (int t = 0; t < 6; t++) begin
            flush();
            pkglen = tbl[t].code;
            write_words(tbl[t].nwords);
            chk($sformatf("tbl%0d_req", t),    req_a,    tbl[t].exp_req);
            chk($sformatf("tbl%0d_ready", t),  ready_a,  tbl[t].exp_ready);
            chk($sformatf("tbl%0d_margin", t), margin_a, tbl[t].exp_margin);
            if (tbl[t].do_ack) begin
                ack = 1'b1;
                cycle();
                ack = 1'b0;
                cycle();
                cycle();
                chk($sformatf("tbl%0d_busy", t),    busy_a,   1'b0);
                chk($sformatf("tbl%0d_val", t),     val_a,    1'b0);
                chk($sformatf("tbl%0d_margin2", t), margin_a, tbl[t].exp_margin);
            end
        end

        // Burst of 8 from 10 buffered words; length change mid-burst
        flush();
        pkglen = 3'd1;
        chx_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            w[k] = $urandom;
            chx_data = w[k];
            cycle();
        end
        chx_valid = 1'b0;
        chk("burst_req", req_a, 1'b1);
        ack = 1'b1;
        cycle();
        ack = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            chk($sformatf("burst_val_k%0d", k),  val_a,  (k >= 2 && k <= 9));
            chk($sformatf("burst_last_k%0d", k), last_a, (k == 9));
            if (k >= 2 && k <= 9) chk($sformatf("burst_data_k%0d", k), data_a, w[k-2]);
            if (k == 3) pkglen = 3'd0;
            if (k < 10) cycle();
        end
        chk("burst_margin_after", margin_a, 7'd62);
        chk("burst_busy_after",   busy_a,   1'b0);

        // Code 7 clamps to 64; only the margin-1 instance can fill that far
        flush();
        pkglen = 3'd7;
        chx_valid = 1'b1;
        for (int k = 0; k < 64; k++) begin
            chx_data = k;
            cycle();
            if (k == 62) chk("c7_req_at63", req_b, 1'b0);
        end
        chx_valid = 1'b0;
        chk("c7_req_at64", req_b,    1'b1);
        chk("c7_margin_b", margin_b, 7'd0);
        chk("c7_ready_b",  ready_b,  1'b0);
        chk("c7_req_a",    req_a,    1'b0);
        ack = 1'b1;
        cycle();
        ack = 1'b0;
        beats = 0;
        lastpos = 0;
        for (int g = 0; g < 80; g++) begin
            cycle();
            if (val_b) beats++;
            if (val_b && last_b) lastpos = beats;
            if (!val_b && !busy_b && beats > 0) break;
        end
        chk("c7_beats",    beats,    64);
        chk("c7_lastpos",  lastpos,  64);
        chk("c7_margin_b_after", margin_b, 7'd64);
        chk("c7_busy_a",   busy_a,   1'b0);
        chk("c7_margin_a", margin_a, 7'd31);

        // Streaming with concurrent writes, random grants, pointer wrap
        flush();
        pkglen = 3'd2;
        in_log.delete();
        out_log.delete();
        log_en = 1'b1;
        guard = 0;
        while (in_log.size() < 200 && guard < 3000) begin
            chx_valid = ($urandom_range(0, 3) != 0);
            chx_data  = $urandom;
            ack       = ($urandom_range(0, 2) == 0);
            cycle();
            guard++;
        end
        chx_valid = 1'b0;
        guard = 0;
        while ((q_size(1) >= 16 || m_send[1] || m_val[1]) && guard < 400) begin
            ack = ($urandom_range(0, 1) == 0);
            cycle();
            guard++;
        end
        ack = 1'b0;
        log_en = 1'b0;
        chk("rand_accepted", in_log.size(), 200);
        chk("rand_out_len",  out_log.size(), in_log.size() - q_size(1));
        bad = -1;
        for (int k = 0; k < out_log.size() && k < in_log.size(); k++) begin
            if (bad < 0 && out_log[k] !== in_log[k]) bad = k;
        end
        chk("rand_order_first_bad", bad, -1);

        // Disable after the third beat, re-enable, then reset mid-burst
        flush();
        pkglen = 3'd1;
        write_words(8);
        ack = 1'b1;
        cycle();
        ack = 1'b0;
        beats = 0;
        for (int g = 0; g < 20; g++) begin
            cycle();
            if (val_a) beats++;
            if (beats == 3) break;
        end
        chk("dis_beats_seen", beats, 3);
        en = 1'b0;
        #1;
        chk("dis_ready_now", ready_a, 1'b0);
        chk("dis_req_now",   req_a,   1'b0);
        cycle();
        chk("dis_val",    val_a,    1'b0);
        chk("dis_last",   last_a,   1'b0);
        chk("dis_margin", margin_a, 7'd64);
        chk("dis_busy",   busy_a,   1'b0);
        en = 1'b1;
        pkglen = 3'd0;
        write_words(4);
        chk("reen_req", req_a, 1'b1);
        ack = 1'b1;
        cycle();
        ack = 1'b0;
        cycle();
        cycle();
        chk("pre_rst_val", val_a, 1'b1);
        rst = 1'b1;
        #1;
        chk("arst_val",    val_a,    1'b0);
        chk("arst_last",   last_a,   1'b0);
        chk("arst_data",   data_a,   32'd0);
        chk("arst_ready",  ready_a,  1'b0);
        chk("arst_req",    req_a,    1'b0);
        chk("arst_margin", margin_a, 7'd64);
        chk("arst_busy",   busy_a,   1'b0);
        chk("arst_val_b",  val_b,    1'b0);
        model_reset();
        cycle();
        rst = 1'b0;
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
